fetch_queue: RTL and testbench

Decoupling instruction buffer between fetch and decode. Accepts up to FETCH_WIDTH fetched instructions per cycle, compacting out invalid lanes. Presents the oldest FETCH_WIDTH entries to decode in program order. Fetch keeps running while decode is stalled, and the buffer is discarded on a branch-miss flush.

---
 rtl/fetch_queue_pkg.sv | 17 +
 rtl/fetch_queue_if.sv | 26 ++
 rtl/fetch_queue_compact.sv | 21 ++
 rtl/fetch_queue.sv | 101 ++++++++++
 tb/tb_fetch_queue.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue.
package fetch_queue_pkg;

    typedef logic [63:0] pc_t;
    typedef logic [31:0] u32;

    typedef struct packed {
        pc_t pc;
        u32  raw_instr;
    } fq_entry_t;

    localparam int unsigned FQ_DEPTH = 8;
    localparam int unsigned FQ_WIDTH = 2;

    typedef logic [$clog2(FQ_DEPTH)-1:0] fq_ptr_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side enqueue and decode-side dequeue bundle of the fetch queue.
interface fetch_queue_if #(
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned PTR_W       = 3
);
    logic                         flush;
    logic [FETCH_WIDTH-1:0]       in_valid;
    logic [FETCH_WIDTH-1:0][63:0] in_pc;
    logic [FETCH_WIDTH-1:0][31:0] in_instr;
    logic                         in_ready;
    logic [FETCH_WIDTH-1:0]       out_valid;
    logic [FETCH_WIDTH-1:0][63:0] out_pc;
    logic [FETCH_WIDTH-1:0][31:0] out_instr;
    logic                         out_ready;
    logic [PTR_W:0]               count;

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/fetch_queue_compact.sv
// Per-lane prefix popcount: offset[i] = number of valid lanes below i, total = popcount.
module fetch_queue_compact #(
    parameter  int unsigned WIDTH = 2,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]            valid,
    output logic [WIDTH-1:0][CNT_W-1:0] offset,
    output logic [CNT_W-1:0]            total
);
    logic [CNT_W-1:0] acc;

    always_comb begin
        acc    = '0;
        offset = '0;
        for (int i = 0; i < WIDTH; i++) begin
            offset[i] = acc;
            acc       = acc + CNT_W'(valid[i]);
        end
        total = acc;
    end
endmodule

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and decode with lane compaction and flush.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH = FQ_WIDTH,
    parameter int unsigned DEPTH       = FQ_DEPTH,
    parameter int unsigned PTR_W       = $clog2(DEPTH)
) (
    input logic         clk,
    input logic         reset,
    fetch_queue_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(FETCH_WIDTH + 1);
    localparam logic [PTR_W:0] READY_MAX = (PTR_W + 1)'(DEPTH - FETCH_WIDTH);

    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t           head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0] count_q, count_d;
    fq_entry_t      mem [DEPTH];

    logic [FETCH_WIDTH-1:0][CNT_W-1:0] enq_offset;
    logic [FETCH_WIDTH-1:0][CNT_W-1:0] deq_offset;
    logic [CNT_W-1:0]                  nenq, ndeq;
    logic                              enq_fire, deq_fire;
    logic                              unused_deq_offset;

    fetch_queue_compact #(.WIDTH(FETCH_WIDTH)) u_enq_compact (
        .valid  (bus.in_valid),
        .offset (enq_offset),
        .total  (nenq)
    );

    // Only the popcount of the presented lanes is needed on the dequeue side.
    fetch_queue_compact #(.WIDTH(FETCH_WIDTH)) u_deq_count (
        .valid  (bus.out_valid),
        .offset (deq_offset),
        .total  (ndeq)
    );

    assign unused_deq_offset = ^deq_offset;

    assign bus.in_ready = (count_q <= READY_MAX);
    assign bus.count    = count_q;
    assign enq_fire     = bus.in_ready && (|bus.in_valid) && !bus.flush;
    assign deq_fire     = bus.out_ready;

    always_comb begin
        bus.out_valid = '0;
        bus.out_pc    = '0;
        bus.out_instr = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            bus.out_valid[i] = (count_q > (PTR_W + 1)'(i)) && !bus.flush;
            bus.out_pc[i]    = mem[head_q + ptr_t'(i)].pc;
            bus.out_instr[i] = mem[head_q + ptr_t'(i)].raw_instr;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) begin
                tail_d  = tail_q + ptr_t'(nenq);
            end
            if (deq_fire) begin
                head_d  = head_q + ptr_t'(ndeq);
            end
            count_d = count_q
                    + (enq_fire ? (PTR_W + 1)'(nenq) : '0)
                    - (deq_fire ? (PTR_W + 1)'(ndeq) : '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is deliberately not reset; count gates visibility.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (enq_fire && bus.in_valid[i]) begin
                mem[tail_q + ptr_t'(enq_offset[i])] <= '{pc: bus.in_pc[i],
                                                         raw_instr: bus.in_instr[i]};
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed-vector bench for fetch_queue with immediate-assertion checks.
module tb_fetch_queue;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    fetch_queue_if #(.FETCH_WIDTH(2), .PTR_W(3)) fq_bus ();

    fetch_queue #(.FETCH_WIDTH(2), .DEPTH(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (fq_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1);
        fq_bus.in_valid    = v;
        fq_bus.in_pc[0]    = p0;
        fq_bus.in_pc[1]    = p1;
        fq_bus.in_instr[0] = p0[31:0] ^ 32'h13;
        fq_bus.in_instr[1] = p1[31:0] ^ 32'h13;
    endtask

    // One rising edge: inputs are driven and outputs sampled at falling edges.
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset            = 1'b1;
        fq_bus.flush     = 1'b0;
        fq_bus.out_ready = 1'b0;
        drive(2'b00, 64'h0, 64'h0);
        #2;
        check("reset_count", 64'(fq_bus.count), 64'd0);
        check("reset_out_valid", 64'(fq_bus.out_valid), 64'd0);
        check("reset_in_ready", 64'(fq_bus.in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;

        // Basic pair enqueue, visible next cycle
        drive(2'b11, 64'h8000_0000, 64'h8000_0004);
        cyc();
        drive(2'b00, 64'h0, 64'h0);
        check("pair_out_valid", 64'(fq_bus.out_valid), 64'd3);
        check("pair_pc0", fq_bus.out_pc[0], 64'h8000_0000);
        check("pair_pc1", fq_bus.out_pc[1], 64'h8000_0004);
        check("pair_instr0", 64'(fq_bus.out_instr[0]), 64'h8000_0013);
        check("pair_count", 64'(fq_bus.count), 64'd2);
        fq_bus.out_ready = 1'b1;
        cyc();
        check("pair_drained", 64'(fq_bus.count), 64'd0);
        check("pair_drained_valid", 64'(fq_bus.out_valid), 64'd0);

        // Fill to full while decode stalls; a fifth push is ignored
        fq_bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 64'h100 + 64'(8 * k), 64'h104 + 64'(8 * k));
            cyc();
        end
        check("full_count", 64'(fq_bus.count), 64'd8);
        check("full_in_ready", 64'(fq_bus.in_ready), 64'd0);
        drive(2'b11, 64'h200, 64'h204);
        cyc();
        drive(2'b00, 64'h0, 64'h0);
        check("full_ignore_count", 64'(fq_bus.count), 64'd8);
        check("full_out_valid", 64'(fq_bus.out_valid), 64'd3);
        fq_bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_pc0", fq_bus.out_pc[0], 64'h100 + 64'(8 * k));
            check("drain_pc1", fq_bus.out_pc[1], 64'h104 + 64'(8 * k));
            cyc();
        end
        check("drain_count", 64'(fq_bus.count), 64'd0);

        // Non-contiguous lanes compact into consecutive entries
        fq_bus.out_ready = 1'b0;
        drive(2'b10, 64'hdead, 64'h14);
        cyc();
        check("nc_count1", 64'(fq_bus.count), 64'd1);
        check("nc_valid1", 64'(fq_bus.out_valid), 64'd1);
        drive(2'b01, 64'h18, 64'hbeef);
        cyc();
        drive(2'b00, 64'h0, 64'h0);
        check("nc_count2", 64'(fq_bus.count), 64'd2);
        check("nc_pc0", fq_bus.out_pc[0], 64'h14);
        check("nc_pc1", fq_bus.out_pc[1], 64'h18);
        fq_bus.out_ready = 1'b1;
        cyc();

        // Walk head/tail from 4 to 7, then straddle the 7->0 boundary
        for (int k = 0; k < 3; k++) begin
            drive(2'b01, 64'h600 + 64'(4 * k), 64'h0);
            cyc();
        end
        drive(2'b00, 64'h0, 64'h0);
        cyc();
        check("wrap_pre_count", 64'(fq_bus.count), 64'd0);
        fq_bus.out_ready = 1'b0;
        drive(2'b11, 64'h700, 64'h704);
        cyc();
        check("wrap_pc0", fq_bus.out_pc[0], 64'h700);
        check("wrap_pc1", fq_bus.out_pc[1], 64'h704);
        check("wrap_count", 64'(fq_bus.count), 64'd2);
        drive(2'b11, 64'h708, 64'h70c);
        cyc();
        drive(2'b00, 64'h0, 64'h0);
        fq_bus.out_ready = 1'b1;
        cyc();
        check("wrap_next_pc0", fq_bus.out_pc[0], 64'h708);
        check("wrap_next_pc1", fq_bus.out_pc[1], 64'h70c);
        cyc();

        // Simultaneous enqueue and dequeue at count=3
        fq_bus.out_ready = 1'b0;
        drive(2'b11, 64'h300, 64'h304);
        cyc();
        drive(2'b01, 64'h308, 64'h0);
        cyc();
        check("sim_pre_count", 64'(fq_bus.count), 64'd3);
        fq_bus.out_ready = 1'b1;
        drive(2'b11, 64'h30c, 64'h310);
        cyc();
        drive(2'b00, 64'h0, 64'h0);
        check("sim_count", 64'(fq_bus.count), 64'd3);
        check("sim_pc0", fq_bus.out_pc[0], 64'h308);
        check("sim_pc1", fq_bus.out_pc[1], 64'h30c);
        cyc();
        check("sim_tail_count", 64'(fq_bus.count), 64'd1);
        check("sim_tail_valid", 64'(fq_bus.out_valid), 64'd1);
        check("sim_tail_pc0", fq_bus.out_pc[0], 64'h310);
        cyc();

        // Flush at count=5 with concurrent push and pop
        fq_bus.out_ready = 1'b0;
        drive(2'b11, 64'h400, 64'h404);
        cyc();
        drive(2'b11, 64'h408, 64'h40c);
        cyc();
        drive(2'b01, 64'h410, 64'h0);
        cyc();
        fq_bus.flush     = 1'b1;
        fq_bus.out_ready = 1'b1;
        drive(2'b11, 64'h4f0, 64'h4f4);
        #1;
        check("flush_cycle_valid", 64'(fq_bus.out_valid), 64'd0);
        check("flush_cycle_count", 64'(fq_bus.count), 64'd5);
        cyc();
        fq_bus.flush     = 1'b0;
        fq_bus.out_ready = 1'b0;
        drive(2'b00, 64'h0, 64'h0);
        #1;
        check("flush_count", 64'(fq_bus.count), 64'd0);
        check("flush_valid", 64'(fq_bus.out_valid), 64'd0);
        check("flush_in_ready", 64'(fq_bus.in_ready), 64'd1);
        drive(2'b11, 64'h500, 64'h504);
        cyc();
        drive(2'b00, 64'h0, 64'h0);
        check("post_flush_pc0", fq_bus.out_pc[0], 64'h500);
        check("post_flush_pc1", fq_bus.out_pc[1], 64'h504);
        check("post_flush_count", 64'(fq_bus.count), 64'd2);

        // Asynchronous reset mid-cycle, observed before the next rising edge
        #2;
        reset = 1'b1;
        #1;
        check("async_count", 64'(fq_bus.count), 64'd0);
        check("async_valid", 64'(fq_bus.out_valid), 64'd0);
        check("async_in_ready", 64'(fq_bus.in_ready), 64'd1);
        #1;
        reset = 1'b0;
        cyc();
        check("after_reset_count", 64'(fq_bus.count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
